// File: rtl/itch_msg_framer_if.sv
`default_nettype none
// ============================================================================
// Module      : itch_msg_framer_if
// Description : Byte-stream bundle between the header stage, the ITCH
//               message framer and the per-type field decoders. The master
//               side feeds bytes in and observes framed output; the slave
//               side is the framer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface itch_msg_framer_if #(
  parameter int IDX_W = 6
);
  // Upstream byte stream from the header stage
  logic [7:0]       byte_in;
  logic             byte_valid_in;
  logic             start_flag_in;

  // Framed stream towards the field decoders
  logic [7:0]       byte_out;
  logic             byte_valid_out;
  logic [IDX_W-1:0] byte_idx_out;
  logic [7:0]       msg_type_out;
  logic [IDX_W-1:0] msg_len_out;
  logic             msg_start_out;
  logic             msg_end_out;
  logic             unknown_type_out;
  logic             truncated_out;

  modport master (
    output byte_in, byte_valid_in, start_flag_in,
    input  byte_out, byte_valid_out, byte_idx_out, msg_type_out,
           msg_len_out, msg_start_out, msg_end_out, unknown_type_out,
           truncated_out
  );

  modport slave (
    input  byte_in, byte_valid_in, start_flag_in,
    output byte_out, byte_valid_out, byte_idx_out, msg_type_out,
           msg_len_out, msg_start_out, msg_end_out, unknown_type_out,
           truncated_out
  );
endinterface
`default_nettype wire

// File: rtl/itch_msg_framer.sv
`default_nettype none
// ============================================================================
// Module      : itch_msg_framer
// Description : Splits the ITCH byte stream into fixed-length messages.
//               Decodes the type byte, looks up the message length, tags
//               each byte with its index and flags start/end, unknown
//               types and truncated messages. One cycle of latency, all
//               outputs registered.
//               Optional feature macro: ITCH_FRAMER_STATS_EN adds saturating
//               message and error counters (msg_count_out, err_count_out).
// Revision    : 1.0 - initial release
// ============================================================================
module itch_msg_framer #(
  parameter int IDX_W = 6  // must be >= 6 to hold the longest length (44)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  itch_msg_framer_if.slave        bus
`ifdef ITCH_FRAMER_STATS_EN
  ,
  output logic [15:0]             msg_count_out,
  output logic [15:0]             err_count_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_SKIP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_count;
  logic [IDX_W-1:0] r_len;

  logic [IDX_W-1:0] w_lookup_len;
  logic             w_known;
  logic             w_type_byte;
  logic             w_trunc;
  logic             w_payload;
  logic             w_last;

  // Fixed message length by type byte; zero marks an unlisted type
  always_comb begin
    w_lookup_len = '0;
    case (bus.byte_in)
      8'h41:   w_lookup_len = IDX_W'(36);  // 'A'
      8'h46:   w_lookup_len = IDX_W'(40);  // 'F'
      8'h45:   w_lookup_len = IDX_W'(31);  // 'E'
      8'h43:   w_lookup_len = IDX_W'(36);  // 'C'
      8'h58:   w_lookup_len = IDX_W'(23);  // 'X'
      8'h44:   w_lookup_len = IDX_W'(19);  // 'D'
      8'h55:   w_lookup_len = IDX_W'(35);  // 'U'
      8'h50:   w_lookup_len = IDX_W'(44);  // 'P'
      default: w_lookup_len = '0;
    endcase
  end

  assign w_known = (w_lookup_len != '0);

  // A type byte is any valid byte in IDLE, or any flagged byte elsewhere;
  // a flagged byte in ACTIVE also cuts the running message short.
  assign w_type_byte = bus.byte_valid_in &&
                       ((r_state == ST_IDLE) || bus.start_flag_in);
  assign w_trunc     = bus.byte_valid_in && bus.start_flag_in &&
                       (r_state == ST_ACTIVE);
  assign w_payload   = bus.byte_valid_in && !bus.start_flag_in &&
                       (r_state == ST_ACTIVE);
  assign w_last      = w_payload && (r_count == (r_len - IDX_W'(1)));

  // Framing FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state              <= ST_IDLE;
      r_count              <= '0;
      r_len                <= '0;
      bus.byte_out         <= '0;
      bus.byte_valid_out   <= 1'b0;
      bus.byte_idx_out     <= '0;
      bus.msg_type_out     <= '0;
      bus.msg_len_out      <= '0;
      bus.msg_start_out    <= 1'b0;
      bus.msg_end_out      <= 1'b0;
      bus.unknown_type_out <= 1'b0;
      bus.truncated_out    <= 1'b0;
    end else begin
      bus.byte_valid_out   <= 1'b0;
      bus.msg_start_out    <= 1'b0;
      bus.msg_end_out      <= 1'b0;
      bus.unknown_type_out <= 1'b0;
      bus.truncated_out    <= w_trunc;

      if (w_type_byte) begin
        if (w_known) begin
          bus.byte_out       <= bus.byte_in;
          bus.byte_valid_out <= 1'b1;
          bus.byte_idx_out   <= '0;
          bus.msg_start_out  <= 1'b1;
          bus.msg_type_out   <= bus.byte_in;
          bus.msg_len_out    <= w_lookup_len;
          r_len              <= w_lookup_len;
          r_count            <= IDX_W'(1);
          r_state            <= ST_ACTIVE;
        end else begin
          // Unknown type: keep the previous type/length, drop until next flag
          bus.unknown_type_out <= 1'b1;
          r_count              <= '0;
          r_state              <= ST_SKIP;
        end
      end else if (w_payload) begin
        bus.byte_out       <= bus.byte_in;
        bus.byte_valid_out <= 1'b1;
        bus.byte_idx_out   <= r_count;
        if (w_last) begin
          bus.msg_end_out <= 1'b1;
          r_count         <= '0;
          r_state         <= ST_IDLE;
        end else begin
          r_count <= r_count + IDX_W'(1);
        end
      end
    end
  end

`ifdef ITCH_FRAMER_STATS_EN
  logic w_err;

  // Unknown type and truncation in the same cycle count as a single error
  assign w_err = w_trunc || (w_type_byte && !w_known);

  // Saturating message/error counters, stepped alongside their pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_count_out <= '0;
      err_count_out <= '0;
    end else begin
      if (w_last && (msg_count_out != 16'hFFFF)) begin
        msg_count_out <= msg_count_out + 16'd1;
      end
      if (w_err && (err_count_out != 16'hFFFF)) begin
        err_count_out <= err_count_out + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_itch_msg_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_itch_msg_framer
// Description : Self-checking bench for itch_msg_framer. Stimulus is built as
//               a list of message segments; the expected framed stream is
//               derived from each segment's type, length and cut point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_itch_msg_framer;
  localparam int IDX_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  itch_msg_framer_if #(.IDX_W(IDX_W)) bus ();

`ifdef ITCH_FRAMER_STATS_EN
  logic [15:0] msg_count_out;
  logic [15:0] err_count_out;
`endif

  itch_msg_framer #(.IDX_W(IDX_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus)
`ifdef ITCH_FRAMER_STATS_EN
    ,
    .msg_count_out (msg_count_out),
    .err_count_out (err_count_out)
`endif
  );

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       sf;
    logic       ev;
    logic [7:0] bo;
    int         idx;
    logic       ms, me, unk, tr;
    logic [7:0] ty;
    int         len;
    int         mc, ec;
  } cyc_t;

  cyc_t q[$];

  // Values the framed stream is expected to hold between events
  logic [7:0] m_bo, m_ty;
  int         m_len, m_msgs, m_errs;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_len(input logic [7:0] t);
    case (t)
      8'h41: return 36;
      8'h46: return 40;
      8'h45: return 31;
      8'h43: return 36;
      8'h58: return 23;
      8'h44: return 19;
      8'h55: return 35;
      8'h50: return 44;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_bo = '0; m_ty = '0; m_len = 0; m_msgs = 0; m_errs = 0;
  endtask

  task automatic push_idle();
    cyc_t c;
    c.v = 1'b0; c.b = 8'($urandom); c.sf = 1'($urandom);
    c.ev = 1'b0; c.idx = 0; c.ms = 0; c.me = 0; c.unk = 0; c.tr = 0;
    c.bo = m_bo; c.ty = m_ty; c.len = m_len; c.mc = m_msgs; c.ec = m_errs;
    q.push_back(c);
  endtask

  // One segment: type byte t followed by n-1 payload bytes. sf flags the
  // first byte, tr says that byte cuts short the previous message.
  task automatic add_seg(input logic [7:0] t, input int n, input bit sf,
                         input bit tr, input int gap_pct,
                         input int g1, input int g2);
    cyc_t c;
    int   L;
    L = ref_len(t);
    for (int i = 0; i < n; i++) begin
      if (i == g1 || i == g2) repeat (3) push_idle();
      if (i > 0 && int'($urandom_range(99)) < gap_pct) push_idle();
      c.v = 1'b1;
      c.b = (i == 0) ? t : 8'($urandom);
      c.sf = (i == 0) ? sf : 1'b0;
      c.tr = (i == 0) && tr;
      c.ev = 0; c.idx = 0; c.ms = 0; c.me = 0; c.unk = 0;
      if (L != 0) begin
        c.ev = 1; c.idx = i; c.ms = (i == 0); c.me = (i == L - 1);
        m_bo = c.b;
        if (i == 0) begin m_ty = t; m_len = L; end
      end else begin
        c.unk = (i == 0);
      end
      if (c.me) m_msgs++;
      if (c.unk || c.tr) m_errs++;
      c.bo = m_bo; c.ty = m_ty; c.len = m_len; c.mc = m_msgs; c.ec = m_errs;
      q.push_back(c);
    end
  endtask

  task automatic play();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      bus.byte_in = c.b; bus.byte_valid_in = c.v; bus.start_flag_in = c.sf;
      @(posedge clk);
      #1;
      n_cyc++;
      check($sformatf("c%0d valid", n_cyc), 32'(bus.byte_valid_out), 32'(c.ev));
      check($sformatf("c%0d pulses{s,e,u,t}", n_cyc),
            {28'd0, bus.msg_start_out, bus.msg_end_out, bus.unknown_type_out,
             bus.truncated_out}, {28'd0, c.ms, c.me, c.unk, c.tr});
      check($sformatf("c%0d byte_out", n_cyc), 32'(bus.byte_out), 32'(c.bo));
      if (c.ev)
        check($sformatf("c%0d idx", n_cyc), 32'(bus.byte_idx_out), 32'(c.idx));
      check($sformatf("c%0d type", n_cyc), 32'(bus.msg_type_out), 32'(c.ty));
      check($sformatf("c%0d len", n_cyc), 32'(bus.msg_len_out), 32'(c.len));
`ifdef ITCH_FRAMER_STATS_EN
      check($sformatf("c%0d msg_count", n_cyc), 32'(msg_count_out), 32'(c.mc));
      check($sformatf("c%0d err_count", n_cyc), 32'(err_count_out), 32'(c.ec));
`endif
    end
    @(negedge clk);
    bus.byte_valid_in = 1'b0; bus.start_flag_in = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " valid"}, 32'(bus.byte_valid_out), 32'd0);
    check({tag, " pulses"}, {28'd0, bus.msg_start_out, bus.msg_end_out,
          bus.unknown_type_out, bus.truncated_out}, 32'd0);
    check({tag, " byte_out"}, 32'(bus.byte_out), 32'd0);
    check({tag, " idx"}, 32'(bus.byte_idx_out), 32'd0);
    check({tag, " type"}, 32'(bus.msg_type_out), 32'd0);
    check({tag, " len"}, 32'(bus.msg_len_out), 32'd0);
`ifdef ITCH_FRAMER_STATS_EN
    check({tag, " msg_count"}, 32'(msg_count_out), 32'd0);
    check({tag, " err_count"}, 32'(err_count_out), 32'd0);
`endif
  endtask

  initial begin
    logic [7:0] kt [8];
    logic [7:0] t;
    bit         prev_inc, prev_unk, sf;
    int         kind, n;
    kt = '{8'h41, 8'h46, 8'h45, 8'h43, 8'h58, 8'h44, 8'h55, 8'h50};

    bus.byte_in = '0; bus.byte_valid_in = 1'b0; bus.start_flag_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios
    add_seg(8'h44, 19, 1, 0, 0, -1, -1);   // single 'D'
    add_seg(8'h58, 23, 1, 0, 0, -1, -1);   // 'X' then 'A' back-to-back
    add_seg(8'h41, 36, 0, 0, 0, -1, -1);
    add_seg(8'h5A, 11, 1, 0, 0, -1, -1);   // unknown + 10 junk bytes
    add_seg(8'h44, 19, 1, 0, 0, -1, -1);
    add_seg(8'h50, 20, 0, 0, 0, -1, -1);   // 'P' cut at idx 20 by 'D'
    add_seg(8'h44, 19, 1, 1, 0, -1, -1);
    add_seg(8'h46, 40, 0, 0, 0, 5, 30);    // 'F' with gaps at idx 5 and 30
    play();

    // Randomized segments: full, cut-short and unknown messages with gaps
    prev_inc = 0; prev_unk = 0;
    for (int s = 0; s < 60; s++) begin
      kind = int'($urandom_range(2));
      sf = (prev_inc || prev_unk) ? 1'b1 : 1'($urandom_range(1));
      if (kind == 2) begin
        t = 8'($urandom);
        for (int k = 0; k < 64 && ref_len(t) != 0; k++) t = t + 8'd1;
        n = int'($urandom_range(1, 12));
        add_seg(t, n, sf, prev_inc, 20, -1, -1);
        prev_unk = 1; prev_inc = 0;
      end else begin
        t = kt[$urandom_range(7)];
        n = (kind == 0) ? ref_len(t) : int'($urandom_range(1, ref_len(t) - 1));
        add_seg(t, n, sf, prev_inc, 20, -1, -1);
        prev_inc = (kind == 1); prev_unk = 0;
      end
    end
    play();

    // Clean restart, then reset in the middle of an 'A' message
    rst_n = 1'b0;
    #1 check_zero("rst_pre");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    add_seg(8'h41, 12, 1, 0, 0, -1, -1);
    play();
    rst_n = 1'b0;
    #1 check_zero("rst_mid");
    @(posedge clk);
    #1 check_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    add_seg(8'h45, 31, 0, 0, 0, -1, -1);   // first byte after reset is a type byte
    play();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/itch_msg_framer.md
# itch_msg_framer

Frames the ITCH byte stream emitted by the header stage into individual messages. Sits directly downstream of the header stage: consumes its forwarded byte, byte-valid and start-of-burst pulse. Decodes the message-type byte, looks up the fixed message length, and tags every byte with its in-message index. Flags message start and end, unknown types, and truncated messages for the per-type field decoders that follow.

## Interface
- IDX_W, 6, width of byte index and length outputs; must be ≥ 6 (max length 44)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- byte_in  in  8  payload byte from header stage
- byte_valid_in  in  1  byte_in valid this cycle
- start_flag_in  in  1  first byte of a new burst from header stage; only meaningful with byte_valid_in
- byte_out  out  8  registered copy of accepted message byte
- byte_valid_out  out  1  byte_out belongs to a framed, known-type message
- byte_idx_out  out  IDX_W  index of byte_out within message (type byte = 0)
- msg_type_out  out  8  type byte of current message, held until next message start
- msg_len_out  out  IDX_W  total length of current message including type byte, held with msg_type_out
- msg_start_out  out  1  1-cycle pulse with index-0 byte
- msg_end_out  out  1  1-cycle pulse with last byte (index = len−1)
- unknown_type_out  out  1  1-cycle pulse when a message begins with an unlisted type byte
- truncated_out  out  1  1-cycle pulse when a message is aborted before its last byte

## Operation
- Length table, total bytes including type byte: 'A'(0x41)=36, 'F'(0x46)=40, 'E'(0x45)=31, 'C'(0x43)=36, 'X'(0x58)=23, 'D'(0x44)=19, 'U'(0x55)=35, 'P'(0x50)=44. All others are unknown.
- FSM states: IDLE, ACTIVE, SKIP. Reset state IDLE.
- IDLE: any valid byte (start_flag_in irrelevant) is a type byte. Known → emit index 0, msg_start_out, latch type/len, count=1, go ACTIVE. Unknown → pulse unknown_type_out, byte_valid_out stays 0, go SKIP.
- ACTIVE, valid byte without start_flag_in: emit byte with index = count, count+1. If index == len−1: pulse msg_end_out, go IDLE. The next valid byte is then the next type byte, so back-to-back messages need no start_flag.
- ACTIVE, valid byte with start_flag_in: pulse truncated_out. Treat the byte as a new type byte in the same cycle, as in IDLE. Possible results: new msg_start_out plus truncated_out together, or unknown_type_out plus truncated_out then SKIP.
- ACTIVE with no valid byte: hold state and count; gaps are tolerated.
- SKIP: discard valid bytes without start_flag_in. A valid byte with start_flag_in is processed as a type byte, as in IDLE.
- msg_type_out/msg_len_out update only on a known-type start; unknown types do not overwrite them.
- Counter never wraps: the len−1 check ends every message; maximum count is 43.

## Timing
- Latency 1 cycle: a byte accepted at edge N appears on all outputs after edge N.
- All outputs are registered. All pulses deassert the following cycle unless re-triggered.
- byte_out holds its last value when byte_valid_out = 0.
- Reset (async assert, any state, mid-message included): all outputs 0, FSM IDLE, count 0. First valid byte after release is a type byte.
- A 1-byte message is impossible (minimum length 19), so msg_start_out and msg_end_out never coincide.

## Configuration
- ITCH_FRAMER_STATS_EN defined: adds outputs msg_count_out[15:0] and err_count_out[15:0], both reset 0.
  - msg_count_out increments on each msg_end_out.
  - err_count_out increments on each cycle with unknown_type_out or truncated_out asserted (+1 even if both assert).
  - Both saturate at 0xFFFF.
- Not defined: these ports and their counters are absent; all other behaviour is identical.

## Test plan
- Single 'D' message of 19 bytes, start_flag_in on byte 0 only.
  - Expect msg_start_out with idx 0, msg_type_out=0x44, msg_len_out=19.
  - Expect idx 0..18 on consecutive cycles, msg_end_out with idx 18, state IDLE.
- Back-to-back 'X'(23) then 'A'(36), continuous valid, one start_flag_in.
  - Expect second msg_start_out exactly one cycle after first msg_end_out, msg_len_out=36.
- Unknown type 0x5A, 10 junk bytes, then 'D' with start_flag_in.
  - Expect unknown_type_out once and byte_valid_out=0 for all 11 skipped bytes.
  - Then expect normal 'D' framing; msg_type_out kept its prior value through the skip.
- 'P' message interrupted at idx 20 by valid byte 0x44 with start_flag_in.
  - Expect truncated_out and msg_start_out in the same cycle, new idx 0, len 19.
- 'F' message with 3-cycle valid gaps at idx 5 and 30, no start_flag_in.
  - Expect indices continuous 0..39, msg_end_out at idx 39, no truncated_out.
- rst_n asserted at idx 12 of an 'A' message, released, then 'E' sent.
  - Expect all outputs 0 during reset and clean 'E' framing (len 31).
  - With ITCH_FRAMER_STATS_EN defined, expect counters 0 after reset, msg_count_out=1 after 'E'.
